// File: rtl/uart_pkg.sv
// Shared UART types and IO port map used by the transmit/receive buffering logic.
package uart_pkg;

    typedef enum logic [1:0] {
        TXF_IDLE    = 2'd0,
        TXF_WAIT_HI = 2'd1,
        TXF_WAIT_LO = 2'd2
    } txf_state_t;

    localparam int unsigned UART_TX_PORT   = 8;
    localparam int unsigned UART_STAT_PORT = 10;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with registered count/full; a push on a full FIFO is accepted
// only when a pop in the same cycle frees the slot.
module sync_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         wdata,
    output logic [WIDTH-1:0]         rdata_c,
    output logic [$clog2(DEPTH):0]   count,
    output logic [$clog2(DEPTH):0]   count_nxt_c,
    output logic                     full
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wptr_q, wptr_d;
    logic [AW-1:0]    rptr_q, rptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             full_q, full_d;
    logic             push_ok_c, pop_ok_c;

    // Pointers wrap naturally because DEPTH is a power of two.
    always_comb begin
        pop_ok_c  = pop && (count_q != CW'(0));
        push_ok_c = push && (!full_q || pop_ok_c);
        wptr_d    = wptr_q + AW'(push_ok_c);
        rptr_d    = rptr_q + AW'(pop_ok_c);
        count_d   = count_q + CW'(push_ok_c) - CW'(pop_ok_c);
        full_d    = (count_d == CW'(DEPTH));
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
            full_q  <= 1'b0;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
            full_q  <= full_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok_c) begin
            mem_q[wptr_q] <= wdata;
        end
    end

    assign rdata_c     = mem_q[rptr_q];
    assign count       = count_q;
    assign count_nxt_c = count_d;
    assign full        = full_q;

endmodule

// File: rtl/uart_tx_fifo.sv
// Transmit buffer: absorbs CPU byte writes and feeds uart_core one byte at a time,
// pacing on the core's busy_tx handshake.
module uart_tx_fifo
    import uart_pkg::*;
#(
    parameter int unsigned DEPTH     = 16,
    parameter int unsigned BUSY_WAIT = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [7:0]             wr_data,
    input  logic                   wr_en,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count,
    output logic                   overflow,
    input  logic                   ovf_clr,
    output logic [7:0]             data_in,
    output logic                   data_in_wr,
    input  logic                   busy_tx
);

    localparam int unsigned CW = $clog2(DEPTH) + 1;
    localparam int unsigned TW = (BUSY_WAIT > 1) ? $clog2(BUSY_WAIT + 1) : 1;

    txf_state_t     state_q, state_d;
    logic [TW-1:0]  timer_q, timer_d;
    logic [7:0]     data_in_q, data_in_d;
    logic           data_in_wr_q, data_in_wr_d;
    logic           overflow_q, overflow_d;
    logic           empty_q, empty_d;
    logic           pop_c;

    logic [7:0]     fifo_rdata_c;
    logic [CW-1:0]  fifo_count;
    logic [CW-1:0]  fifo_count_nxt_c;
    logic           fifo_full;

    sync_fifo #(
        .WIDTH (8),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk         (clk),
        .reset       (reset),
        .push        (wr_en),
        .pop         (pop_c),
        .wdata       (wr_data),
        .rdata_c     (fifo_rdata_c),
        .count       (fifo_count),
        .count_nxt_c (fifo_count_nxt_c),
        .full        (fifo_full)
    );

    // Drain FSM: issue a byte, then give the core BUSY_WAIT clocks to claim it.
    always_comb begin
        state_d      = state_q;
        timer_d      = timer_q;
        data_in_d    = data_in_q;
        data_in_wr_d = 1'b0;
        pop_c        = 1'b0;

        case (state_q)
            TXF_IDLE: begin
                if ((fifo_count != CW'(0)) && !busy_tx) begin
                    pop_c        = 1'b1;
                    data_in_d    = fifo_rdata_c;
                    data_in_wr_d = 1'b1;
                    timer_d      = TW'(BUSY_WAIT);
                    state_d      = TXF_WAIT_HI;
                end
            end
            TXF_WAIT_HI: begin
                if (busy_tx) begin
                    state_d = TXF_WAIT_LO;
                end else if (timer_q == TW'(0)) begin
                    state_d = TXF_IDLE;
                end else begin
                    timer_d = timer_q - TW'(1);
                end
            end
            TXF_WAIT_LO: begin
                if (!busy_tx) begin
                    state_d = TXF_IDLE;
                end
            end
            default: state_d = TXF_IDLE;
        endcase

        // A discarded push sets overflow even when ovf_clr is asserted alongside it.
        overflow_d = overflow_q;
        if (wr_en && fifo_full && !pop_c) begin
            overflow_d = 1'b1;
        end else if (ovf_clr) begin
            overflow_d = 1'b0;
        end

        empty_d = (fifo_count_nxt_c == CW'(0)) && (state_d == TXF_IDLE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= TXF_IDLE;
            timer_q      <= '0;
            data_in_q    <= '0;
            data_in_wr_q <= 1'b0;
            overflow_q   <= 1'b0;
            empty_q      <= 1'b1;
        end else begin
            state_q      <= state_d;
            timer_q      <= timer_d;
            data_in_q    <= data_in_d;
            data_in_wr_q <= data_in_wr_d;
            overflow_q   <= overflow_d;
            empty_q      <= empty_d;
        end
    end

    assign full       = fifo_full;
    assign empty      = empty_q;
    assign count      = fifo_count;
    assign overflow   = overflow_q;
    assign data_in    = data_in_q;
    assign data_in_wr = data_in_wr_q;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Bench for uart_tx_fifo: queue-based reference model checked every cycle, a simple
// uart_core stand-in, and directed scenarios with literal expectations.
`timescale 1ns/1ps
module tb_uart_tx_fifo;

    localparam int unsigned DEPTH     = 16;
    localparam int unsigned BUSY_WAIT = 4;

    logic       clk     = 1'b0;
    logic       reset   = 1'b1;
    logic [7:0] wr_data = 8'h00;
    logic       wr_en   = 1'b0;
    logic       ovf_clr = 1'b0;
    logic       busy_tx = 1'b0;
    logic       full, empty, overflow, data_in_wr;
    logic [4:0] count;
    logic [7:0] data_in;

    int vectors    = 0;
    int miscompares = 0;

    uart_tx_fifo #(.DEPTH(DEPTH), .BUSY_WAIT(BUSY_WAIT)) dut (
        .clk        (clk),
        .reset      (reset),
        .wr_data    (wr_data),
        .wr_en      (wr_en),
        .full       (full),
        .empty      (empty),
        .count      (count),
        .overflow   (overflow),
        .ovf_clr    (ovf_clr),
        .data_in    (data_in),
        .data_in_wr (data_in_wr),
        .busy_tx    (busy_tx)
    );

    always #5 clk = ~clk;

    function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endfunction

    // Reference model: byte queue plus "transfer in progress" phase with an absolute
    // deadline for the core to raise busy (edges n+1 .. n+BUSY_WAIT+1 after a pop at n).
    logic [7:0] mq[$];
    logic [7:0] m_data;
    bit         m_ovf, m_wr, m_valid, do_pop, was_full;
    int         m_phase;   // 0 free, 1 waiting for busy rise, 2 waiting for busy fall
    int         win_end;
    int         cyc = 0;

    always @(posedge clk) begin
        cyc++;
        if (reset) begin
            mq.delete();
            m_ovf = 0; m_data = 8'h00; m_wr = 0; m_phase = 0; m_valid = 1;
        end else begin
            was_full = (mq.size() == DEPTH);
            do_pop   = (m_phase == 0) && (mq.size() > 0) && !busy_tx;
            m_wr     = 0;
            if (m_phase == 1) begin
                if (busy_tx) m_phase = 2;
                else if (cyc >= win_end) m_phase = 0;
            end else if (m_phase == 2) begin
                if (!busy_tx) m_phase = 0;
            end
            if (do_pop) begin
                m_data  = mq.pop_front();
                m_wr    = 1;
                m_phase = 1;
                win_end = cyc + BUSY_WAIT + 1;
            end
            if (wr_en && (!was_full || do_pop)) mq.push_back(wr_data);
            if (wr_en && was_full && !do_pop) m_ovf = 1;
            else if (ovf_clr) m_ovf = 0;
        end
    end

    always @(negedge clk) begin
        if (m_valid) begin
            check("cmp_count", 32'(count), 32'(mq.size()));
            check("cmp_full", 32'(full), 32'(mq.size() == DEPTH));
            check("cmp_empty", 32'(empty), 32'((mq.size() == 0) && (m_phase == 0)));
            check("cmp_overflow", 32'(overflow), 32'(m_ovf));
            check("cmp_data_in_wr", 32'(data_in_wr), 32'(m_wr));
            check("cmp_data_in", 32'(data_in), 32'(m_data));
        end
    end

    // uart_core stand-in: mode 0 accepts a strobe and stays busy busy_len clks,
    // mode 1 holds busy high, mode 2 never raises busy (bytes are lost).
    int         core_mode = 0;
    int         busy_len  = 3;
    int         busy_cnt  = 0;
    int         strobes   = 0;
    logic [7:0] rx[$];
    int         strobe_cyc[$];

    always @(posedge clk) begin
        #1;
        if (data_in_wr) begin
            strobes++;
            strobe_cyc.push_back(cyc);
        end
        if (core_mode == 1) begin
            busy_tx = 1'b1;
        end else if (core_mode == 2) begin
            busy_tx  = 1'b0;
            busy_cnt = 0;
        end else if (data_in_wr) begin
            rx.push_back(data_in);
            busy_cnt = busy_len;
            busy_tx  = 1'b1;
        end else if (busy_cnt > 0) begin
            busy_cnt--;
            busy_tx = (busy_cnt > 0);
        end else begin
            busy_tx = 1'b0;
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic push(input logic [7:0] b);
        wr_data = b;
        wr_en   = 1'b1;
        tick();
        wr_en   = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        rx.delete();
        strobe_cyc.delete();
        strobes = 0;
    endtask

    task automatic wait_rx(input int n, input int budget);
        for (int i = 0; i < budget && rx.size() < n; i++) tick();
        check("rx_len", 32'(rx.size()), 32'(n));
    endtask

    int pushed;

    initial begin
        tick();
        // 1: single byte, 2-clk latency, full handshake back to empty
        do_reset();
        @(negedge clk);
        check("rst_count", 32'(count), 32'd0);
        check("rst_empty", 32'(empty), 32'd1);
        check("rst_full", 32'(full), 32'd0);
        check("rst_ovf", 32'(overflow), 32'd0);
        check("rst_data_in", 32'(data_in), 32'h00);
        check("rst_wr", 32'(data_in_wr), 32'd0);
        push(8'h41);
        @(negedge clk);
        check("t1_wr_clk1", 32'(data_in_wr), 32'd0);
        tick();
        @(negedge clk);
        check("t1_wr_clk2", 32'(data_in_wr), 32'd1);
        check("t1_data", 32'(data_in), 32'h41);
        tick();
        @(negedge clk);
        check("t1_wr_clk3", 32'(data_in_wr), 32'd0);
        check("t1_busy_not_empty", 32'(empty), 32'd0);
        repeat (10) tick();
        check("t1_empty", 32'(empty), 32'd1);
        wait_rx(1, 5);
        if (rx.size() > 0) check("t1_rx0", 32'(rx[0]), 32'h41);

        // 2: fill while core busy, overflow on 17th, ordered drain
        do_reset();
        core_mode = 1;
        tick();
        for (int i = 0; i < 16; i++) push(8'(i));
        @(negedge clk);
        check("t2_full", 32'(full), 32'd1);
        check("t2_count", 32'(count), 32'd16);
        push(8'hEE);
        @(negedge clk);
        check("t2_ovf", 32'(overflow), 32'd1);
        check("t2_count17", 32'(count), 32'd16);
        core_mode = 0;
        wait_rx(16, 400);
        for (int i = 0; i < 16 && i < rx.size(); i++) check("t2_rx", 32'(rx[i]), 32'(i));
        check("t2_ovf_sticky", 32'(overflow), 32'd1);

        // 3: push exactly on each pop while full, three laps
        do_reset();
        core_mode = 1;
        tick();
        for (int i = 0; i < 16; i++) push(8'(i));
        core_mode = 0;
        pushed = 16;
        for (int c = 0; c < 3000 && pushed < 64; c++) begin
            if ((m_phase == 0) && (mq.size() > 0) && !busy_tx) begin
                wr_data = 8'(pushed);
                wr_en   = 1'b1;
                pushed++;
            end else begin
                wr_en = 1'b0;
            end
            tick();
        end
        wr_en = 1'b0;
        @(negedge clk);
        check("t3_pushed", 32'(pushed), 32'd64);
        check("t3_count", 32'(count), 32'd16);
        check("t3_ovf", 32'(overflow), 32'd0);
        wait_rx(64, 1500);
        for (int i = 0; i < 64 && i < rx.size(); i++) check("t3_rx", 32'(rx[i]), 32'(i));

        // 4: core never answers -> timeout, next byte after BUSY_WAIT+2 clks
        do_reset();
        core_mode = 2;
        tick();
        push(8'hAA);
        push(8'hBB);
        for (int i = 0; i < 50 && strobes < 2; i++) tick();
        check("t4_strobes", 32'(strobes), 32'd2);
        if (strobe_cyc.size() >= 2) check("t4_gap", 32'(strobe_cyc[1] - strobe_cyc[0]), 32'd6);
        repeat (10) tick();
        check("t4_rx_none", 32'(rx.size()), 32'd0);
        check("t4_ovf", 32'(overflow), 32'd0);
        check("t4_empty", 32'(empty), 32'd1);
        core_mode = 0;

        // 5: reset while waiting for busy to fall with 5 bytes queued
        do_reset();
        busy_len = 20;
        for (int i = 0; i < 6; i++) push(8'(8'h50 + i));
        tick();
        @(negedge clk);
        check("t5_count", 32'(count), 32'd5);
        check("t5_not_empty", 32'(empty), 32'd0);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        @(negedge clk);
        check("t5_rst_count", 32'(count), 32'd0);
        check("t5_rst_empty", 32'(empty), 32'd1);
        check("t5_rst_wr", 32'(data_in_wr), 32'd0);
        strobes = 0;
        repeat (30) tick();
        check("t5_no_strobes", 32'(strobes), 32'd0);
        busy_len = 3;

        // 6: overflow clear, and set beating clear in the same cycle
        do_reset();
        core_mode = 1;
        tick();
        for (int i = 0; i < 17; i++) push(8'(8'hC0 + i));
        @(negedge clk);
        check("t6_ovf_set", 32'(overflow), 32'd1);
        ovf_clr = 1'b1;
        tick();
        ovf_clr = 1'b0;
        @(negedge clk);
        check("t6_ovf_clr", 32'(overflow), 32'd0);
        wr_data = 8'hFF;
        wr_en   = 1'b1;
        ovf_clr = 1'b1;
        tick();
        wr_en   = 1'b0;
        ovf_clr = 1'b0;
        @(negedge clk);
        check("t6_set_wins", 32'(overflow), 32'd1);
        check("t6_count", 32'(count), 32'd16);
        core_mode = 0;
        wait_rx(16, 400);
        for (int i = 0; i < 16 && i < rx.size(); i++) check("t6_rx", 32'(rx[i]), 32'(8'hC0 + i));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
